// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizing for the two-port data-memory arbiter.
package dmem_arbiter_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int ADDR_WIDTH   = 10;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 3;

  localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } darb_state_e;

  typedef struct packed {
    logic  owner;
    logic  we;
    addr_t addr;
    data_t wdata;
  } dmem_cmd_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes (index 0 = MEM stage, 1 = debug/loader) plus the memory port.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic [1:0]  req;
  logic [1:0]  we;
  addr_t [1:0] addr;
  data_t [1:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  data_t [1:0] rdata;
  logic        stall;

  logic        mem_en;
  logic        mem_we;
  addr_t       mem_addr;
  data_t       mem_wdata;
  data_t       mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_prio.sv
// Winner select: port 0 by default, port 1 when alone or after STARVE_LIMIT consecutive losses.
module dmem_arb_prio
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [1:0] req,
  output logic       winner
);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner       = req[1] & (~req[0] | (starve_cnt_q == STARVE_MAX));
    starve_cnt_d = starve_cnt_q;
    // Only decisions taken in IDLE move the counter; a losing port 1 accrues credit.
    if (arb_en) begin
      if (!req[1] || winner) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory controller shared by the MEM stage and the debug/loader port.
// State updates on the falling clock edge to line up with the pipeline stages.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic          I_CLOCK,
  input  logic          I_RESET_N,
  dmem_arbiter_if.slave bus
);
  darb_state_e      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  dmem_cmd_t        cmd_q, cmd_d;
  logic [1:0]       done_q, done_d;
  data_t [1:0]      rdata_q, rdata_d;
  logic             winner;
  logic             issue;

  dmem_arb_prio u_prio (
    .clk    (I_CLOCK),
    .rst_n  (I_RESET_N),
    .arb_en (state_q == ST_IDLE),
    .req    (bus.req),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    done_d  = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          cmd_d.owner = winner;
          cmd_d.we    = bus.we[winner];
          cmd_d.addr  = bus.addr[winner];
          cmd_d.wdata = bus.wdata[winner];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_W'(MEM_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          done_d[cmd_q.owner] = 1'b1;
          if (!cmd_q.we) rdata_d[cmd_q.owner] = bus.mem_rdata;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // The memory bus is forced to zero outside the single ISSUE cycle.
  assign issue         = (state_q == ST_ISSUE);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & cmd_q.we;
  assign bus.mem_addr  = issue ? cmd_q.addr  : '0;
  assign bus.mem_wdata = issue ? cmd_q.wdata : '0;
  assign bus.gnt       = issue ? (cmd_q.owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.stall     = bus.req[0] & ~done_q[0];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected issues/completions plus a latency memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    logic  port;
    logic  we;
    addr_t addr;
    data_t wdata;
  } iss_t;

  typedef struct {
    logic  port;
    logic  we;
    data_t rdata;
  } cmp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .bus       (bus)
  );

  iss_t  iss_q[$];
  cmp_t  cmp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    en_cnt = 0;
  int    done_cnt = 0;
  data_t model_rdata [2];
  data_t mem [1024];
  logic  pv [MEM_LATENCY+1];
  addr_t pa [MEM_LATENCY+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: writes land on the strobe, loads return MEM_LATENCY cycles later, junk otherwise.
  always @(posedge clk) begin
    for (int i = MEM_LATENCY; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = bus.mem_en & ~bus.mem_we;
    pa[0] = bus.mem_addr;
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata = pv[MEM_LATENCY] ? mem[pa[MEM_LATENCY]] : data_t'($urandom);
  end

  always @(posedge clk) begin : monitor
    iss_t ei;
    cmp_t ec;
    if (bus.mem_en) en_cnt++;
    if (bus.gnt != 2'b00 || bus.mem_en) begin
      if (iss_q.size() == 0) begin
        chk("issue_unexpected", 32'({bus.gnt, bus.mem_en}), 32'd0);
      end else begin
        ei = iss_q.pop_front();
        chk("iss_gnt_en", 32'({bus.gnt, bus.mem_en}), 32'({(ei.port ? 2'b10 : 2'b01), 1'b1}));
        chk("iss_we", 32'(bus.mem_we), 32'(ei.we));
        chk("iss_addr", 32'(bus.mem_addr), 32'(ei.addr));
        chk("iss_wdata", 32'(bus.mem_wdata), 32'(ei.wdata));
      end
    end else begin
      chk("idle_bus_zero", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    end
    if (bus.done != 2'b00) begin
      done_cnt++;
      if (cmp_q.size() == 0) begin
        chk("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
        ec = cmp_q.pop_front();
        chk("done_port", 32'(bus.done), 32'(ec.port ? 2'b10 : 2'b01));
        if (!ec.we) model_rdata[ec.port] = ec.rdata;
        chk("done_rdata", 32'(bus.rdata[ec.port]), 32'(model_rdata[ec.port]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic p, input logic we, input addr_t a, input data_t wd);
    iss_q.push_back('{port: p, we: we, addr: a, wdata: wd});
  endtask

  task automatic push_cmp(input logic p, input logic we, input data_t rd);
    cmp_q.push_back('{port: p, we: we, rdata: rd});
  endtask

  task automatic set_port(input int p, input logic we, input addr_t a, input data_t wd);
    bus.req[p]   = 1'b1;
    bus.we[p]    = we;
    bus.addr[p]  = a;
    bus.wdata[p] = wd;
  endtask

  task automatic wait_gnt(input int p, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.gnt[p] && n < 20);
  endtask

  task automatic wait_done(input int p, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done[p] && n < 20);
  endtask

  // Requester holds REQ until its DONE, as the pipeline does.
  task automatic access(input string tag, input int p, input logic we, input addr_t a,
                        input data_t wd, input data_t exp_rd);
    int n;
    push_iss(p[0], we, a, wd);
    push_cmp(p[0], we, exp_rd);
    set_port(p, we, a, wd);
    wait_gnt(p, n);
    chk({tag, "_gnt_latency"}, 32'(n), 32'd1);
    if (p == 0) chk({tag, "_stall_at_gnt"}, 32'(bus.stall), 32'd1);
    wait_done(p, n);
    chk({tag, "_done_latency"}, 32'(n), 32'(MEM_LATENCY + 1));
    if (p == 0) chk({tag, "_stall_at_done"}, 32'(bus.stall), 32'd0);
    bus.req[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int e0;
    int d0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i <= MEM_LATENCY; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = data_t'(i) ^ 16'h5A5A;
    mem[10'h012] = 16'hBEEF;
    model_rdata[0] = '0;
    model_rdata[1] = '0;

    // Reset held with both ports requesting: nothing may issue.
    set_port(0, 1'b0, 10'h005, 16'h0000);
    set_port(1, 1'b0, 10'h006, 16'h0000);
    repeat (3) begin
      tick();
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rdata", 32'({bus.rdata[1], bus.rdata[0]}), 32'd0);
    end
    push_iss(1'b0, 1'b0, 10'h005, 16'h0000);
    push_cmp(1'b0, 1'b0, 16'h5A5F);
    rst_n = 1'b1;
    tick();
    chk("rst_release_gnt", 32'(bus.gnt), 32'b01);
    bus.req[1] = 1'b0;
    wait_done(0, n);
    chk("rst_release_done_latency", 32'(n), 32'(MEM_LATENCY + 1));
    bus.req[0] = 1'b0;
    tick();

    // Port 0 load.
    access("load_m0", 0, 1'b0, 10'h012, 16'h0000, 16'hBEEF);
    chk("load_m0_rdata", 32'(bus.rdata[0]), 32'hBEEF);

    // Port 1 store, then read it back.
    e0 = en_cnt;
    access("store_m1", 1, 1'b1, 10'h3FF, 16'h1234, 16'h0000);
    chk("store_m1_strobes", 32'(en_cnt - e0), 32'd1);
    chk("store_m1_rdata_kept", 32'(bus.rdata[1]), 32'd0);
    access("load_m1", 1, 1'b0, 10'h3FF, 16'h0000, 16'h1234);

    // Contention: both held, expect 0,0,0,1,0,0,0,1.
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        push_iss(1'b1, 1'b0, 10'h030, 16'h0000);
        push_cmp(1'b1, 1'b0, 16'h5A6A);
      end else begin
        push_iss(1'b0, 1'b0, 10'h020, 16'h0000);
        push_cmp(1'b0, 1'b0, 16'h5A7A);
      end
    end
    set_port(0, 1'b0, 10'h020, 16'h0000);
    set_port(1, 1'b0, 10'h030, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.gnt == 2'b00 && n < 20);
      chk($sformatf("contend_grant_%0d", k), 32'(bus.gnt), 32'((k % 4 == 3) ? 2'b10 : 2'b01));
    end
    bus.req = 2'b00;
    wait_done(1, n);
    chk("contend_last_done_latency", 32'(n), 32'(MEM_LATENCY + 1));
    chk("contend_done_count", 32'(done_cnt - d0), 32'd8);
    tick();

    // Reset one cycle after GNT abandons the access.
    push_iss(1'b0, 1'b0, 10'h040, 16'h0000);
    set_port(0, 1'b0, 10'h040, 16'h0000);
    wait_gnt(0, n);
    chk("midrst_gnt_latency", 32'(n), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req[0] = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    e0 = en_cnt;
    d0 = done_cnt;
    repeat (6) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_strobe", 32'(en_cnt - e0), 32'd0);
    chk("midrst_rdata_cleared", 32'({bus.rdata[1], bus.rdata[0]}), 32'd0);
    access("after_rst", 1, 1'b0, 10'h3FF, 16'h0000, 16'h1234);
    tick();

    // Port 1 alone, port 0 arrives during its WAIT and is served right after.
    push_iss(1'b1, 1'b0, 10'h030, 16'h0000);
    push_iss(1'b0, 1'b0, 10'h012, 16'h0000);
    push_cmp(1'b1, 1'b0, 16'h5A6A);
    push_cmp(1'b0, 1'b0, 16'hBEEF);
    set_port(1, 1'b0, 10'h030, 16'h0000);
    wait_gnt(1, n);
    chk("sim_m1_gnt_latency", 32'(n), 32'd1);
    tick();
    set_port(0, 1'b0, 10'h012, 16'h0000);
    wait_done(1, n);
    chk("sim_m1_done_latency", 32'(n), 32'd2);
    chk("sim_no_gnt_at_m1_done", 32'(bus.gnt), 32'd0);
    chk("sim_stall_while_waiting", 32'(bus.stall), 32'd1);
    bus.req[1] = 1'b0;
    tick();
    chk("sim_m0_gnt_after_m1_done", 32'(bus.gnt), 32'b01);
    wait_done(0, n);
    chk("sim_m0_done_latency", 32'(n), 32'(MEM_LATENCY + 1));
    bus.req[0] = 1'b0;

    repeat (5) tick();
    chk("sb_issue_drained", 32'(iss_q.size()), 32'd0);
    chk("sb_done_drained", 32'(cmp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
